ft600_device_model: RTL and testbench



---
 rtl/ft600_pkg.sv | 17 +
 rtl/ft600_sync_fifo.sv | 81 ++++++++
 rtl/ft600_device_model.sv | 125 ++++++++++++
 tb/tb_ft600_device_model.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft600_pkg.sv
// ft600_pkg
// Shared constants for the FT600 245-style synchronous FIFO device model.
//   FT_DATA_W / FT_BE_W : default FT data and byte-enable widths
//   FT_ADDR_W           : default log2 depth of each internal FIFO
//   ERR_*               : bit positions inside the sticky err vector
package ft600_pkg;

  localparam int FT_DATA_W = 16;
  localparam int FT_BE_W   = FT_DATA_W / 8;
  localparam int FT_ADDR_W = 4;

  localparam int ERR_W        = 3;
  localparam int ERR_RD_EMPTY = 0;
  localparam int ERR_WR_FULL  = 1;
  localparam int ERR_CONFLICT = 2;

endpackage

// File: rtl/ft600_sync_fifo.sv
// ft600_sync_fifo
// First-word-fall-through synchronous FIFO, 2^ADDR_W entries of WIDTH bits.
// Ports:
//   clk, rst          : clock and synchronous active-high clear
//   push, wdata       : write request and data (ignored when full)
//   pop               : read request (ignored when empty)
//   rdata             : current head word (valid while !empty)
//   full, empty, count: state before this edge
//   full_next, empty_next : state that will hold after this edge
module ft600_sync_fifo #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              full_next,
  output logic              empty_next
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              push_ok;
  logic              pop_ok;

  // Acceptance uses the pre-edge count only, so a pop in the same cycle
  // never makes room for a push into a full FIFO.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  assign full_next  = !rst && (count_nxt == FULL_COUNT);
  assign empty_next = rst || (count_nxt == '0);

  // Pointers are ADDR_W wide so they wrap at the FIFO depth on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
    end
  end

  // Storage needs no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/ft600_device_model.sv
// ft600_device_model
// Chip-side responder for the FT600 245-style synchronous FIFO bus.
// Ports:
//   clk, rst                        : FT bus clock, synchronous active-high reset
//   ft_oe_n/ft_rd_n/ft_wr_n/ft_reset_n : FPGA-driven active-low controls
//   ft_data_i, ft_be_i              : FPGA write data and byte enables
//   ft_rxf_n, ft_txe_n              : data-available / space-available flags
//   ft_data_o, ft_be_o, ft_bus_oe   : tristate source for the shared data bus
//   host_in_*                       : valid/ready stream toward the FPGA (rxq)
//   host_out_*                      : valid/ready stream from the FPGA (txq)
//   err                             : sticky protocol error flags
module ft600_device_model
  import ft600_pkg::*;
#(
  parameter int ADDR_W = FT_ADDR_W,
  parameter int DATA_W = FT_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ft_oe_n,
  input  logic                ft_rd_n,
  input  logic                ft_wr_n,
  input  logic                ft_reset_n,
  input  logic [DATA_W-1:0]   ft_data_i,
  input  logic [DATA_W/8-1:0] ft_be_i,
  output logic                ft_rxf_n,
  output logic                ft_txe_n,
  output logic [DATA_W-1:0]   ft_data_o,
  output logic [DATA_W/8-1:0] ft_be_o,
  output logic                ft_bus_oe,
  input  logic [DATA_W-1:0]   host_in_data,
  input  logic [DATA_W/8-1:0] host_in_be,
  input  logic                host_in_valid,
  output logic                host_in_ready,
  output logic [DATA_W-1:0]   host_out_data,
  output logic [DATA_W/8-1:0] host_out_be,
  output logic                host_out_valid,
  input  logic                host_out_ready,
  output logic [ERR_W-1:0]    err
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WORD_W = BE_W + DATA_W;

  logic              flush;
  logic              rxq_push, rxq_pop, rxq_full, rxq_empty, rxq_empty_next;
  logic              txq_push, txq_pop, txq_full, txq_empty, txq_full_next;
  logic [WORD_W-1:0] rxq_head, txq_head;
  logic [ERR_W-1:0]  err_set;

  // Probe-only FIFO outputs that the bus logic does not need.
  logic [ADDR_W:0]   unused_rxq_count, unused_txq_count;
  logic              unused_rxq_full_next, unused_txq_empty_next;

  // The FT reset pin and the system reset clear the datapath identically.
  assign flush = rst || !ft_reset_n;

  assign host_in_ready  = !rxq_full;
  assign host_out_valid = !txq_empty;

  assign rxq_push = host_in_valid && !rxq_full;
  assign rxq_pop  = !ft_oe_n && !ft_rd_n && !rxq_empty;
  assign txq_push = !ft_wr_n && ft_oe_n && !txq_full;
  assign txq_pop  = host_out_ready && !txq_empty;

  ft600_sync_fifo #(.ADDR_W(ADDR_W), .WIDTH(WORD_W)) rxq (
    .clk        (clk),
    .rst        (flush),
    .push       (rxq_push),
    .wdata      ({host_in_be, host_in_data}),
    .pop        (rxq_pop),
    .rdata      (rxq_head),
    .full       (rxq_full),
    .empty      (rxq_empty),
    .count      (unused_rxq_count),
    .full_next  (unused_rxq_full_next),
    .empty_next (rxq_empty_next)
  );

  ft600_sync_fifo #(.ADDR_W(ADDR_W), .WIDTH(WORD_W)) txq (
    .clk        (clk),
    .rst        (flush),
    .push       (txq_push),
    .wdata      ({ft_be_i, ft_data_i}),
    .pop        (txq_pop),
    .rdata      (txq_head),
    .full       (txq_full),
    .empty      (txq_empty),
    .count      (unused_txq_count),
    .full_next  (txq_full_next),
    .empty_next (unused_txq_empty_next)
  );

  assign host_out_be   = txq_head[WORD_W-1:DATA_W];
  assign host_out_data = txq_head[DATA_W-1:0];

  // The bus is only driven once the FPGA has turned it around; otherwise
  // the source holds zero so a resolved bus never sees stale head data.
  assign ft_be_o   = ft_bus_oe ? rxq_head[WORD_W-1:DATA_W] : '0;
  assign ft_data_o = ft_bus_oe ? rxq_head[DATA_W-1:0]      : '0;

  always_comb begin
    err_set               = '0;
    err_set[ERR_RD_EMPTY] = !ft_rd_n && rxq_empty;
    err_set[ERR_WR_FULL]  = !ft_wr_n && ft_oe_n && txq_full;
    err_set[ERR_CONFLICT] = !ft_wr_n && !ft_oe_n;
  end

  // Flags come from the FIFOs' next-state view, so they already reflect
  // this edge's push/pop when they update.
  always_ff @(posedge clk) begin
    if (flush) begin
      err       <= '0;
      ft_rxf_n  <= 1'b1;
      ft_txe_n  <= 1'b1;
      ft_bus_oe <= 1'b0;
    end else begin
      err       <= err | err_set;
      ft_rxf_n  <= rxq_empty_next;
      ft_txe_n  <= txq_full_next;
      ft_bus_oe <= !ft_oe_n;
    end
  end

endmodule

// File: tb/tb_ft600_device_model.sv
// tb_ft600_device_model
// Self-checking bench for ft600_device_model (ADDR_W=4, DATA_W=16).
// Stimulus pushes expected words into per-direction queues; two monitors
// pop and compare whenever a word leaves the model on either side.
module tb_ft600_device_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        ft_oe_n, ft_rd_n, ft_wr_n, ft_reset_n;
  logic [15:0] ft_data_i;
  logic [1:0]  ft_be_i;
  logic        ft_rxf_n, ft_txe_n, ft_bus_oe;
  logic [15:0] ft_data_o;
  logic [1:0]  ft_be_o;
  logic [15:0] host_in_data;
  logic [1:0]  host_in_be;
  logic        host_in_valid, host_in_ready;
  logic [15:0] host_out_data;
  logic [1:0]  host_out_be;
  logic        host_out_valid, host_out_ready;
  logic [2:0]  err;

  logic [17:0] exp_ft[$];
  logic [17:0] exp_host[$];
  int          n_compared   = 0;
  int          n_mismatched = 0;

  ft600_device_model #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .ft_oe_n        (ft_oe_n),
    .ft_rd_n        (ft_rd_n),
    .ft_wr_n        (ft_wr_n),
    .ft_reset_n     (ft_reset_n),
    .ft_data_i      (ft_data_i),
    .ft_be_i        (ft_be_i),
    .ft_rxf_n       (ft_rxf_n),
    .ft_txe_n       (ft_txe_n),
    .ft_data_o      (ft_data_o),
    .ft_be_o        (ft_be_o),
    .ft_bus_oe      (ft_bus_oe),
    .host_in_data   (host_in_data),
    .host_in_be     (host_in_be),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_be    (host_out_be),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Let the currently driven inputs be sampled by the next rising edge,
  // then return shortly after it so outputs can be read safely.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic hostPush(input logic [15:0] data, input logic [1:0] be);
    host_in_data  = data;
    host_in_be    = be;
    host_in_valid = 1'b1;
    exp_ft.push_back({be, data});
    applyStimulus();
    host_in_valid = 1'b0;
  endtask

  task automatic ftWrite(input logic [15:0] data, input logic [1:0] be,
                         input bit expect_stored);
    ft_data_i = data;
    ft_be_i   = be;
    ft_wr_n   = 1'b0;
    if (expect_stored) exp_host.push_back({be, data});
    applyStimulus();
    ft_wr_n = 1'b1;
  endtask

  // FT-side capture: the FPGA takes the head on an edge where it holds
  // OE and RD low while the model advertises data.
  always @(negedge clk) begin
    if (rst === 1'b0 && ft_reset_n && !ft_oe_n && !ft_rd_n && ft_rxf_n === 1'b0) begin
      if (exp_ft.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL ft_read_unexpected: got 0x%0h, expected no word", {ft_be_o, ft_data_o});
      end else begin
        checkOutput("ft_read_word", 32'({ft_be_o, ft_data_o}), 32'(exp_ft.pop_front()));
      end
    end
  end

  // Host-side drain of words the FPGA wrote.
  always @(negedge clk) begin
    if (rst === 1'b0 && ft_reset_n && host_out_valid === 1'b1 && host_out_ready) begin
      if (exp_host.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL host_out_unexpected: got 0x%0h, expected no word", {host_out_be, host_out_data});
      end else begin
        checkOutput("host_out_word", 32'({host_out_be, host_out_data}), 32'(exp_host.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] burst_words [4];
    burst_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    rst            = 1'b1;
    ft_oe_n        = 1'b1;
    ft_rd_n        = 1'b1;
    ft_wr_n        = 1'b1;
    ft_reset_n     = 1'b1;
    ft_data_i      = '0;
    ft_be_i        = '0;
    host_in_data   = '0;
    host_in_be     = '0;
    host_in_valid  = 1'b0;
    host_out_ready = 1'b0;

    // Reset held for three edges, flags idle-high throughout.
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("reset_rxf_n", 32'(ft_rxf_n), 32'd1);
      checkOutput("reset_txe_n", 32'(ft_txe_n), 32'd1);
    end
    checkOutput("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("release_txe_n", 32'(ft_txe_n), 32'd0);
    checkOutput("release_rxf_n", 32'(ft_rxf_n), 32'd1);
    checkOutput("release_host_in_ready", 32'(host_in_ready), 32'd1);
    checkOutput("release_host_out_valid", 32'(host_out_valid), 32'd0);
    checkOutput("release_bus_oe", 32'(ft_bus_oe), 32'd0);
    checkOutput("release_data_o", 32'(ft_data_o), 32'd0);

    // Host to FPGA burst of four words.
    for (int i = 0; i < 4; i++) begin
      hostPush(burst_words[i], 2'b11);
      if (i == 0) checkOutput("rxf_latency", 32'(ft_rxf_n), 32'd0);
    end
    ft_oe_n = 1'b0;
    applyStimulus();
    checkOutput("burst_bus_oe", 32'(ft_bus_oe), 32'd1);
    checkOutput("burst_head", 32'(ft_data_o), 32'h1111);
    ft_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("burst_rxf_before_last", 32'(ft_rxf_n), 32'd0);
    applyStimulus();
    checkOutput("burst_rxf_after_last", 32'(ft_rxf_n), 32'd1);
    ft_rd_n = 1'b1;
    ft_oe_n = 1'b1;
    applyStimulus();
    checkOutput("burst_bus_released", 32'(ft_bus_oe), 32'd0);
    checkOutput("burst_err", 32'(err), 32'd0);

    // FPGA to host fill: 16 words fit, the 17th is dropped.
    for (int i = 0; i < 17; i++) begin
      ftWrite(16'hC000 + 16'(i), 2'(i), i < 16);
      if (i == 14) checkOutput("fill_txe_before_full", 32'(ft_txe_n), 32'd0);
      if (i == 15) begin
        checkOutput("fill_txe_full", 32'(ft_txe_n), 32'd1);
        checkOutput("fill_err_not_yet", 32'(err), 32'd0);
      end
    end
    checkOutput("fill_err_wr_full", 32'(err), 32'b010);
    checkOutput("fill_host_out_valid", 32'(host_out_valid), 32'd1);
    host_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus();
    host_out_ready = 1'b0;
    checkOutput("drain_empty", 32'(host_out_valid), 32'd0);
    checkOutput("drain_txe_n", 32'(ft_txe_n), 32'd0);

    // Pulse the FT reset pin to clear the sticky error.
    ft_reset_n = 1'b0;
    applyStimulus();
    ft_reset_n = 1'b1;
    checkOutput("flush_clears_err", 32'(err), 32'd0);
    applyStimulus();

    // Concurrent host push and FT pop on a one-word rxq.
    hostPush(16'hAAAA, 2'b01);
    ft_oe_n = 1'b0;
    applyStimulus();
    ft_rd_n       = 1'b0;
    host_in_data  = 16'hBBBB;
    host_in_be    = 2'b10;
    host_in_valid = 1'b1;
    exp_ft.push_back({2'b10, 16'hBBBB});
    applyStimulus();
    host_in_valid = 1'b0;
    checkOutput("concurrent_rxf_n", 32'(ft_rxf_n), 32'd0);
    checkOutput("concurrent_head", 32'({ft_be_o, ft_data_o}), 32'({2'b10, 16'hBBBB}));
    applyStimulus();
    checkOutput("concurrent_count_one", 32'(ft_rxf_n), 32'd1);
    ft_rd_n = 1'b1;
    ft_oe_n = 1'b1;
    applyStimulus();
    checkOutput("concurrent_err", 32'(err), 32'd0);

    // Protocol errors: read while empty, then write during turnaround.
    ft_oe_n = 1'b0;
    ft_rd_n = 1'b0;
    applyStimulus();
    ft_rd_n = 1'b1;
    checkOutput("err_rd_empty", 32'(err), 32'b001);
    ftWrite(16'hDEAD, 2'b11, 1'b0);
    ft_oe_n = 1'b1;
    checkOutput("err_conflict", 32'(err), 32'b101);
    checkOutput("conflict_no_word", 32'(host_out_valid), 32'd0);
    applyStimulus();

    // Flush in the middle of traffic in both directions.
    hostPush(16'h5001, 2'b11);
    hostPush(16'h5002, 2'b01);
    hostPush(16'h5003, 2'b10);
    ftWrite(16'h6001, 2'b11, 1'b1);
    ftWrite(16'h6002, 2'b01, 1'b1);
    ft_oe_n = 1'b0;
    applyStimulus();
    ft_rd_n = 1'b0;
    applyStimulus();
    ft_reset_n = 1'b0;
    exp_ft.delete();
    exp_host.delete();
    applyStimulus();
    ft_reset_n = 1'b1;
    ft_rd_n    = 1'b1;
    ft_oe_n    = 1'b1;
    checkOutput("flush_rxf_n", 32'(ft_rxf_n), 32'd1);
    checkOutput("flush_err", 32'(err), 32'd0);
    checkOutput("flush_host_out_valid", 32'(host_out_valid), 32'd0);
    checkOutput("flush_host_in_ready", 32'(host_in_ready), 32'd1);
    checkOutput("flush_bus_oe", 32'(ft_bus_oe), 32'd0);
    checkOutput("flush_txe_n", 32'(ft_txe_n), 32'd1);
    applyStimulus();
    checkOutput("post_flush_txe_n", 32'(ft_txe_n), 32'd0);
    checkOutput("post_flush_rxf_n", 32'(ft_rxf_n), 32'd1);

    checkOutput("ft_queue_drained", 32'(exp_ft.size()), 32'd0);
    checkOutput("host_queue_drained", 32'(exp_host.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
